scan_chain_loader: RTL and testbench
====================================

# scan_chain_loader

Serial transmitter that drives the configuration scan chain. Accepts one packed 71-bit configuration word over a valid/ready handshake, shifts it out LSB-first on `si` with `se` asserted for exactly CHAIN_LEN cycles, then signals completion. It sits between the host/config controller and the `scan_chain` register block, and is the only driver of that block's `se`/`si`.

## Interface
- `CHAIN_LEN`, 71: total scan-chain length in bits; must equal the sum of all field widths.
- `CNT_W`, `$clog2(CHAIN_LEN+1)`: width of the shift counter; derived, not overridden.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `cfg_valid` input 1: configuration word offered.
- `cfg_ready` output 1: loader can accept a word.
- `cfg_word` input CHAIN_LEN: packed `{H,R,E,C,M,N,U,V,n,e,p,q,r,t,X}`, with H in the MSBs and X at bit 0.
- `se` output 1: scan enable to the chain.
- `si` output 1: serial data to the chain head (H register).
- `so` input 1: serial data from the chain tail (X register).
- `busy` output 1: high from accept until `done`, inclusive.
- `done` output 1: one-cycle pulse after the last shift.
- `rb_word` output CHAIN_LEN: previous chain contents in `cfg_word` layout (readback builds only).
- `rb_valid` output 1: one-cycle pulse, coincident with `done` (readback builds only).

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset value is IDLE.
- IDLE: `cfg_ready`=1 and `se`=0. On `cfg_valid && cfg_ready`, latch `cfg_word` into the shift register, clear the counter, and go to SHIFT.
- SHIFT: `se`=1 and `si` = shift_reg[0]. Each edge shifts shift_reg right by one and increments the counter. After CHAIN_LEN edges (counter == CHAIN_LEN-1 at the edge), go to DONE.
- Bit order: `cfg_word` bit 0 (X) is sent first, and bit CHAIN_LEN-1 (H MSB) is sent last. The chain shifts toward its tail, so after CHAIN_LEN shifts each register holds its field exactly.
- DONE: `se`=0, `done`=1, `busy`=1 for one cycle, then go to IDLE.
- `cfg_ready` is 0 outside IDLE. `cfg_valid` outside IDLE is ignored; no queuing.
- `cfg_word` is sampled only at the accept edge. Later changes have no effect on the transfer in progress.
- Reset asserted mid-transfer: `se` drops to 0 immediately (asynchronously), the FSM goes to IDLE, no `done` is produced, and the chain holds a partial value. Software must reload.
- Reset values: `cfg_ready`=1 (once reset deasserts), `se`=0, `si`=0, `busy`=0, `done`=0, `rb_word`=0, `rb_valid`=0. The counter and shift_reg are 0.
- `si` is 0 whenever `se`=0.

## Timing
- Accept at edge k.
- `se`=1 during cycles k+1 through k+CHAIN_LEN (71 cycles).
- `done`=1 during cycle k+CHAIN_LEN+1.
- `cfg_ready`=1 again in cycle k+CHAIN_LEN+2.
- Back-to-back throughput: one word per CHAIN_LEN+2 cycles.
- `se`, `si`, `done`, and `busy` are registered outputs with no combinational path from inputs. `cfg_ready` is decoded from the state only.

## Configuration
- Macro: `SCAN_READBACK_EN`.
- When defined:
  - `so` is sampled at every SHIFT edge into the MSB of `rb_shift`, which shifts right.
  - At the DONE cycle, `rb_word` holds the chain's pre-load contents in `cfg_word` layout, and `rb_valid` pulses.
  - `rb_word` holds its value until the next DONE.
- When undefined:
  - `so` is unused.
  - `rb_word` is tied to 0 and `rb_valid` is tied to 0.
  - No readback flops are built.

## Structure
- Package `scan_cfg_pkg` holds:
  - The field width localparams (H=8, R=4, E=6, C=10, M=10, N=3, U=3, V=2, n=3, e=8, p=5, q=3, r=2, t=3, X=1).
  - `CHAIN_LEN` = 71.
  - The packed struct `scan_cfg_t` in MSB-to-LSB order H…X.
  - The FSM state enum `scan_ld_state_e`.
- One sub-module is natural: `scan_piso`, a CHAIN_LEN-bit load/shift register with an LSB serial output. It is instantiated for transmit; the readback register is inline.

## Test plan
- Load `cfg_word` with H=8'hA5, X=1, all other fields 0, into a `scan_chain` instance → after `done`: H=8'hA5, X=1, all other outputs 0; `se` was high for exactly 71 cycles.
- Walking-one `cfg_word` = 1<<k for k = 0, 35, 70 → exactly one chain output bit is set, at position k of the packed layout.
- Two back-to-back accepts, with `cfg_valid` held high → the second accept occurs exactly 73 cycles after the first; `cfg_valid` asserted during SHIFT/DONE is not accepted.
- Reset asserted at SHIFT cycle 30 → `se` drops to 0 within the same cycle, no `done` is seen, `cfg_ready`=1 after release, and a fresh load completes correctly.
- `SCAN_READBACK_EN`: load word A = all-ones, then word B = 71'h0_5555… → the second `rb_valid` presents `rb_word` = A, and the chain holds B.
- Without `SCAN_READBACK_EN`: toggle `so` randomly during a load → `rb_word`=0 and `rb_valid`=0 throughout; the transmit result is unchanged.

Source files
------------

// File: rtl/scan_chain_loader_pkg.sv
// ============================================================================
// Module   : scan_cfg_pkg
// Purpose  : Scan-chain field widths, packed configuration layout, loader FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scan_cfg_pkg;

  localparam int H_W  = 8;
  localparam int R_W  = 4;
  localparam int E_W  = 6;
  localparam int C_W  = 10;
  localparam int M_W  = 10;
  localparam int N_W  = 3;
  localparam int U_W  = 3;
  localparam int V_W  = 2;
  localparam int LN_W = 3;
  localparam int LE_W = 8;
  localparam int LP_W = 5;
  localparam int LQ_W = 3;
  localparam int LR_W = 2;
  localparam int LT_W = 3;
  localparam int X_W  = 1;

  localparam int CHAIN_LEN = H_W + R_W + E_W + C_W + M_W + N_W + U_W + V_W +
                             LN_W + LE_W + LP_W + LQ_W + LR_W + LT_W + X_W;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

  // H occupies the MSBs, X is bit 0 (first bit out on si)
  typedef struct packed {
    logic [H_W-1:0]  H;
    logic [R_W-1:0]  R;
    logic [E_W-1:0]  E;
    logic [C_W-1:0]  C;
    logic [M_W-1:0]  M;
    logic [N_W-1:0]  N;
    logic [U_W-1:0]  U;
    logic [V_W-1:0]  V;
    logic [LN_W-1:0] n;
    logic [LE_W-1:0] e;
    logic [LP_W-1:0] p;
    logic [LQ_W-1:0] q;
    logic [LR_W-1:0] r;
    logic [LT_W-1:0] t;
    logic [X_W-1:0]  X;
  } scan_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } scan_ld_state_e;

endpackage

`default_nettype wire

// File: rtl/scan_chain_loader_if.sv
// ============================================================================
// Module   : scan_chain_loader_if
// Purpose  : Configuration-word valid/ready handshake between host and loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scan_chain_loader_if;
  import scan_cfg_pkg::*;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CHAIN_LEN-1:0] cfg_word;

  modport master (output cfg_valid, output cfg_word, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_word, output cfg_ready);

endinterface

`default_nettype wire

// File: rtl/scan_chain_loader_piso.sv
// ============================================================================
// Module   : scan_piso
// Purpose  : CHAIN_LEN-bit parallel-load, right-shift register; exposes the LSB
//            value it will hold after the current edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_piso
  import scan_cfg_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 load,
  input  wire logic                 shift,
  input  wire logic [CHAIN_LEN-1:0] d,
  output logic                      sout_next
);

  logic [CHAIN_LEN-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = d;
    end else if (shift) begin
      shreg_d = {1'b0, shreg_q[CHAIN_LEN-1:1]};
    end
  end

  // Lets the owner register si so it lines up with the shifted data
  assign sout_next = shreg_d[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/scan_chain_loader.sv
// ============================================================================
// Module   : scan_chain_loader
// Purpose  : Shifts one configuration word LSB-first into the scan chain.
//            Optional readback of the previous chain contents: SCAN_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_chain_loader
  import scan_cfg_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 reset,
  scan_chain_loader_if.slave        cfg,
  output logic                      se,
  output logic                      si,
  input  wire logic                 so,
  output logic                      busy,
  output logic                      done,
  output logic [CHAIN_LEN-1:0]      rb_word,
  output logic                      rb_valid
);

  scan_ld_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             se_q, se_d, si_q, si_d, busy_q, busy_d, done_q, done_d;
  logic             load, shift, last, sout_next;

  assign last = (cnt_q == CNT_W'(CHAIN_LEN - 1));

  scan_piso u_piso (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .d         (cfg.cfg_word),
    .sout_next (sout_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg.cfg_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they align with it
    se_d   = (state_d == ST_SHIFT);
    si_d   = se_d & sout_next;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      se_q    <= se_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cfg.cfg_ready = (state_q == ST_IDLE);
  assign se            = se_q;
  assign si            = si_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef SCAN_READBACK_EN
  logic [CHAIN_LEN-1:0] rb_shift_q, rb_shift_d, rb_word_q, rb_word_d;
  logic                 rb_valid_q, rb_valid_d;

  // The chain tail leaves first, so it ends up at bit 0 after CHAIN_LEN samples
  always_comb begin
    rb_shift_d = rb_shift_q;
    rb_word_d  = rb_word_q;
    rb_valid_d = 1'b0;
    if (shift) begin
      rb_shift_d = {so, rb_shift_q[CHAIN_LEN-1:1]};
      if (last) begin
        rb_word_d  = rb_shift_d;
        rb_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_shift_q <= '0;
      rb_word_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_shift_q <= rb_shift_d;
      rb_word_q  <= rb_word_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_word  = rb_word_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_so;
  assign unused_so = so;
  assign rb_word   = '0;
  assign rb_valid  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scan_chain_loader.sv
// ============================================================================
// Module   : tb_scan_chain_loader
// Purpose  : Self-checking bench for scan_chain_loader with a behavioural chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_chain_loader;
  import scan_cfg_pkg::*;

  localparam int L = CHAIN_LEN;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         se, si, so, busy, done, rb_valid;
  logic [L-1:0] rb_word;
  logic [L-1:0] chain = '0;
  logic         use_noise = 1'b0;
  logic         so_noise = 1'b0;

  int total = 0;
  int bad   = 0;
  int se_cycles = 0;
  int done_cnt  = 0;
  int proto_bad = 0;
  int cyc = 0;
  int           acc_log[$];
  logic [L-1:0] pre_log[$];
  logic [L-1:0] done_log[$];
  logic [L-1:0] rb_log[$];

  scan_chain_loader_if cfg_if ();

  scan_chain_loader dut (
    .clk      (clk),
    .reset    (rst_n),
    .cfg      (cfg_if),
    .se       (se),
    .si       (si),
    .so       (so),
    .busy     (busy),
    .done     (done),
    .rb_word  (rb_word),
    .rb_valid (rb_valid)
  );

  always #5 clk = ~clk;

  // Behavioural scan chain: head receives si, tail (X) drives so
  always @(posedge clk) if (se) chain <= {si, chain[L-1:1]};
  assign so = use_noise ? so_noise : chain[0];
  always @(negedge clk) so_noise = 1'($urandom_range(0, 1));

  // Monitor sees pre-edge values of every signal
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && cfg_if.cfg_valid && cfg_if.cfg_ready) begin
      acc_log.push_back(cyc);
      pre_log.push_back(chain);
    end
    if (se) se_cycles <= se_cycles + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_log.push_back(chain);
    end
    if (rb_valid) rb_log.push_back(rb_word);
    if (!se && si) proto_bad <= proto_bad + 1;
    if (busy !== (se | done)) proto_bad <= proto_bad + 1;
`ifdef SCAN_READBACK_EN
    if (rb_valid !== done) proto_bad <= proto_bad + 1;
`else
    if (rb_valid !== 1'b0 || rb_word !== '0) proto_bad <= proto_bad + 1;
`endif
  end

  function automatic logic [L-1:0] rand_word();
    logic [L-1:0] w;
    for (int i = 0; i < L; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  // Offer w for one edge, wait for done, return in the cycle after done
  task automatic run_load(input logic [L-1:0] w, output int lat, output bit to);
    int n;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_word  = w;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_word  = rand_word();
    n = 1;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    to  = (done !== 1'b1);
    lat = n;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_word  = '0;
    repeat (3) @(negedge clk);
    total++; if (se !== 1'b0)   begin bad++; $display("FAIL reset_se got=%b exp=0", se); end
    total++; if (si !== 1'b0)   begin bad++; $display("FAIL reset_si got=%b exp=0", si); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (rb_word !== '0 || rb_valid !== 1'b0)
      begin bad++; $display("FAIL reset_rb got=%h/%b exp=0/0", rb_word, rb_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (cfg_if.cfg_ready !== 1'b1)
      begin bad++; $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready); end
  endtask

  task automatic test_field_load();
    scan_cfg_t s, got;
    logic [L-1:0] w;
    int lat, se0;
    bit to;
    s = '0; s.H = 8'hA5; s.X = 1'b1; w = s;
    se0 = se_cycles;
    run_load(w, lat, to);
    total++; if (to || lat != L + 1) begin bad++; $display("FAIL field_latency got=%0d exp=%0d", lat, L + 1); end
    total++; if (se_cycles - se0 != L) begin bad++; $display("FAIL field_se_len got=%0d exp=%0d", se_cycles - se0, L); end
    got = done_log[$];
    total++; if (got.H !== 8'hA5 || got.X !== 1'b1 || done_log[$] !== w)
      begin bad++; $display("FAIL field_chain got=%h exp=%h", done_log[$], w); end
    total++; if (cfg_if.cfg_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL field_after got=rdy%b done%b busy%b exp=1/0/0", cfg_if.cfg_ready, done, busy); end
  endtask

  task automatic test_walking_one();
    int ks[3] = '{0, 35, 70};
    logic [L-1:0] w;
    int lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      w = '0; w[ks[i]] = 1'b1;
      run_load(w, lat, to);
      total++; if (to || done_log[$] !== w || $countones(done_log[$]) != 1)
        begin bad++; $display("FAIL walk_%0d got=%h exp=%h", ks[i], done_log[$], w); end
    end
  endtask

  task automatic test_random();
    logic [L-1:0] w;
    int lat, se0;
    bit to;
    for (int i = 0; i < 4; i++) begin
      w = rand_word();
      se0 = se_cycles;
      run_load(w, lat, to);
      total++; if (to || lat != L + 1 || se_cycles - se0 != L || done_log[$] !== w)
        begin bad++; $display("FAIL rand_%0d got=%h lat=%0d se=%0d exp=%h", i, done_log[$], lat, se_cycles - se0, w); end
`ifdef SCAN_READBACK_EN
      total++; if (rb_log[$] !== pre_log[$])
        begin bad++; $display("FAIL rand_rb_%0d got=%h exp=%h", i, rb_log[$], pre_log[$]); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [L-1:0] w1, w2;
    int a0, d0, n;
    w1 = rand_word(); w2 = rand_word();
    a0 = acc_log.size(); d0 = done_log.size();
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_word  = w1;
    n = 0;
    while (acc_log.size() < a0 + 1 && n < 10) begin @(negedge clk); n++; end
    cfg_if.cfg_word = w2;
    n = 0;
    while (acc_log.size() < a0 + 2 && n < 200) begin @(negedge clk); n++; end
    cfg_if.cfg_valid = 1'b0;
    n = 0;
    while (done_log.size() < d0 + 2 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    total++; if (acc_log.size() != a0 + 2)
      begin bad++; $display("FAIL b2b_accepts got=%0d exp=2", acc_log.size() - a0); end
    total++; if (acc_log.size() < a0 + 2 || acc_log[a0 + 1] - acc_log[a0] != L + 2)
      begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", (acc_log.size() >= a0 + 2) ? acc_log[a0 + 1] - acc_log[a0] : -1, L + 2); end
    total++; if (done_log.size() < d0 + 2 || done_log[d0] !== w1 || done_log[d0 + 1] !== w2)
      begin bad++; $display("FAIL b2b_words got=%h exp=%h", done_log[$], w2); end
  endtask

  task automatic test_reset_mid();
    logic [L-1:0] w;
    int d0, lat;
    bit to;
    d0 = done_cnt;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_word  = rand_word();
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    repeat (30) @(negedge clk);
    total++; if (se !== 1'b1) begin bad++; $display("FAIL midrst_pre_se got=%b exp=1", se); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (se !== 1'b0 || si !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL midrst_async got=se%b si%b busy%b exp=0/0/0", se, si, busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", done_cnt - d0); end
    total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", cfg_if.cfg_ready); end
    w = rand_word();
    run_load(w, lat, to);
    total++; if (to || lat != L + 1 || done_log[$] !== w)
      begin bad++; $display("FAIL midrst_reload got=%h exp=%h", done_log[$], w); end
  endtask

`ifdef SCAN_READBACK_EN
  task automatic test_readback();
    logic [L-1:0] a, b;
    int lat;
    bit to;
    a = '1;
    for (int i = 0; i < L; i++) b[i] = (i % 2 == 0);
    run_load(a, lat, to);
    run_load(b, lat, to);
    total++; if (to || rb_log[$] !== a) begin bad++; $display("FAIL readback_word got=%h exp=%h", rb_log[$], a); end
    total++; if (done_log[$] !== b)     begin bad++; $display("FAIL readback_chain got=%h exp=%h", done_log[$], b); end
  endtask
`else
  task automatic test_no_readback();
    logic [L-1:0] w;
    int lat;
    bit to;
    w = rand_word();
    use_noise = 1'b1;
    run_load(w, lat, to);
    use_noise = 1'b0;
    total++; if (to || done_log[$] !== w) begin bad++; $display("FAIL norb_chain got=%h exp=%h", done_log[$], w); end
    total++; if (rb_word !== '0 || rb_valid !== 1'b0)
      begin bad++; $display("FAIL norb_outputs got=%h/%b exp=0/0", rb_word, rb_valid); end
  endtask
`endif

  task automatic test_protocol();
    total++; if (proto_bad != 0)
      begin bad++; $display("FAIL protocol_violations got=%0d exp=0", proto_bad); end
  endtask

  initial begin
    test_reset();
    test_field_load();
    test_walking_one();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef SCAN_READBACK_EN
    test_readback();
`else
    test_no_readback();
`endif
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
